// File: rtl/ram_1r1w_arb.sv
// ram_1r1w_arb: two-writer / two-reader round-robin front end for an external
// RAM with one write port and one asynchronous read port. Read responses are
// registered with a latency of one cycle.
// Optional feature: define RAM_1R1W_ARB_CLEAR_EN to zero the whole RAM after
// reset before arbitration starts (busy_o is high during that sweep).
module ram_1r1w_arb #(
   parameter int DataWidth  = 8,
   parameter int NumEntries = 8,
   localparam int AW = $clog2(NumEntries)
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 wr0_valid_i,
   output logic                 wr0_ready_o,
   input  logic [AW-1:0]        wr0_addr_i,
   input  logic [DataWidth-1:0] wr0_data_i,
   input  logic                 wr1_valid_i,
   output logic                 wr1_ready_o,
   input  logic [AW-1:0]        wr1_addr_i,
   input  logic [DataWidth-1:0] wr1_data_i,
   input  logic                 rd0_valid_i,
   output logic                 rd0_ready_o,
   input  logic [AW-1:0]        rd0_addr_i,
   output logic [DataWidth-1:0] rd0_data_o,
   output logic                 rd0_rvalid_o,
   input  logic                 rd1_valid_i,
   output logic                 rd1_ready_o,
   input  logic [AW-1:0]        rd1_addr_i,
   output logic [DataWidth-1:0] rd1_data_o,
   output logic                 rd1_rvalid_o,
   output logic                 ram_wr_valid_o,
   output logic [AW-1:0]        ram_wr_addr_o,
   output logic [DataWidth-1:0] ram_wr_data_o,
   output logic [AW-1:0]        ram_rd_addr_o,
   input  logic [DataWidth-1:0] ram_rd_data_i,
   output logic                 busy_o
);

   typedef enum logic {
      CLEAR,
      RUN
   } state_e;

   state_e state;
   logic   active;
   logic   wr_ptr;
   logic   rd_ptr;
   logic   wr_any;
   logic   wr_sel;
   logic   rd_any;
   logic   rd_sel;

`ifdef RAM_1R1W_ARB_CLEAR_EN
   localparam logic [AW-1:0] LastAddr = AW'(NumEntries - 1);
   logic [AW-1:0] clr_cnt;
`endif

   // Arbitration is only live in RUN; holding reset also blocks every grant.
   assign active = (state == RUN) && reset_ni;

   // Round-robin choice for each side: the pointer breaks ties, a lone requester always wins.
   always_comb begin
      wr_any = active && (wr0_valid_i || wr1_valid_i);
      wr_sel = (wr0_valid_i && wr1_valid_i) ? wr_ptr : wr1_valid_i;
      rd_any = active && (rd0_valid_i || rd1_valid_i);
      rd_sel = (rd0_valid_i && rd1_valid_i) ? rd_ptr : rd1_valid_i;
   end

   assign wr0_ready_o = wr_any && !wr_sel;
   assign wr1_ready_o = wr_any && wr_sel;
   assign rd0_ready_o = rd_any && !rd_sel;
   assign rd1_ready_o = rd_any && rd_sel;

   assign ram_rd_addr_o = rd_sel ? rd1_addr_i : rd0_addr_i;

   // RAM write port: the write winner in RUN, or the zeroing sweep in CLEAR.
   always_comb begin
      ram_wr_valid_o = wr_any;
      ram_wr_addr_o  = wr_sel ? wr1_addr_i : wr0_addr_i;
      ram_wr_data_o  = wr_sel ? wr1_data_i : wr0_data_i;
`ifdef RAM_1R1W_ARB_CLEAR_EN
      if (state == CLEAR) begin
         ram_wr_valid_o = reset_ni;
         ram_wr_addr_o  = clr_cnt;
         ram_wr_data_o  = '0;
      end
`endif
   end

   // Pointers move to the loser after a grant and hold when nothing is granted.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (wr_any) wr_ptr <= !wr_sel;
         if (rd_any) rd_ptr <= !rd_sel;
      end
   end

   // Read response: the asynchronous RAM data is captured at the grant edge, so a same-cycle write is not yet visible.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rd0_rvalid_o <= 1'b0;
         rd1_rvalid_o <= 1'b0;
         rd0_data_o   <= '0;
         rd1_data_o   <= '0;
      end else begin
         rd0_rvalid_o <= rd0_ready_o;
         rd1_rvalid_o <= rd1_ready_o;
         if (rd0_ready_o) rd0_data_o <= ram_rd_data_i;
         if (rd1_ready_o) rd1_data_o <= ram_rd_data_i;
      end
   end

`ifdef RAM_1R1W_ARB_CLEAR_EN
   // CLEAR walks every address once, then hands over to RUN; busy mirrors CLEAR.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= CLEAR;
         busy_o  <= 1'b1;
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == LastAddr) begin
            state  <= RUN;
            busy_o <= 1'b0;
         end
      end
   end
`else
   // Without the clear sweep the block comes out of reset straight into RUN.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= RUN;
      else           state <= RUN;
   end

   assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_1r1w_arb.sv
// tb_ram_1r1w_arb: directed bench for ram_1r1w_arb with a behavioural RAM
// (synchronous write, asynchronous read). Works with or without
// RAM_1R1W_ARB_CLEAR_EN defined.
module tb_ram_1r1w_arb;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       wr0_valid_i, wr1_valid_i, rd0_valid_i, rd1_valid_i;
   logic       wr0_ready_o, wr1_ready_o, rd0_ready_o, rd1_ready_o;
   logic [2:0] wr0_addr_i, wr1_addr_i, rd0_addr_i, rd1_addr_i;
   logic [7:0] wr0_data_i, wr1_data_i;
   logic [7:0] rd0_data_o, rd1_data_o;
   logic       rd0_rvalid_o, rd1_rvalid_o;
   logic       ram_wr_valid_o;
   logic [2:0] ram_wr_addr_o, ram_rd_addr_o;
   logic [7:0] ram_wr_data_o, ram_rd_data_i;
   logic       busy_o;

   logic [7:0] mem [8];
   int         checks = 0;
   int         errors = 0;

   ram_1r1w_arb #(.DataWidth(8), .NumEntries(8)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .wr0_valid_i(wr0_valid_i), .wr0_ready_o(wr0_ready_o),
      .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
      .wr1_valid_i(wr1_valid_i), .wr1_ready_o(wr1_ready_o),
      .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
      .rd0_valid_i(rd0_valid_i), .rd0_ready_o(rd0_ready_o),
      .rd0_addr_i(rd0_addr_i), .rd0_data_o(rd0_data_o), .rd0_rvalid_o(rd0_rvalid_o),
      .rd1_valid_i(rd1_valid_i), .rd1_ready_o(rd1_ready_o),
      .rd1_addr_i(rd1_addr_i), .rd1_data_o(rd1_data_o), .rd1_rvalid_o(rd1_rvalid_o),
      .ram_wr_valid_o(ram_wr_valid_o), .ram_wr_addr_o(ram_wr_addr_o),
      .ram_wr_data_o(ram_wr_data_o), .ram_rd_addr_o(ram_rd_addr_o),
      .ram_rd_data_i(ram_rd_data_i), .busy_o(busy_o)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk_i = ~clk_i;

   // Behavioural RAM: asynchronous read, write on the rising edge.
   assign ram_rd_data_i = mem[ram_rd_addr_o];

   always @(posedge clk_i) begin
      if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(
      input logic w0v, input logic [2:0] w0a, input logic [7:0] w0d,
      input logic w1v, input logic [2:0] w1a, input logic [7:0] w1d,
      input logic r0v, input logic [2:0] r0a,
      input logic r1v, input logic [2:0] r1a);
      wr0_valid_i = w0v; wr0_addr_i = w0a; wr0_data_i = w0d;
      wr1_valid_i = w1v; wr1_addr_i = w1a; wr1_data_i = w1d;
      rd0_valid_i = r0v; rd0_addr_i = r0a;
      rd1_valid_i = r1v; rd1_addr_i = r1a;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Releases reset, then (when the sweep is built in) checks the full CLEAR pass.
   task automatic releaseAndClear();
      reset_ni = 1'b1;
      #1;
`ifdef RAM_1R1W_ARB_CLEAR_EN
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 8'h77, 1, 2, 8'h66, 1, 1, 1, 2);
         checkOutput($sformatf("clr_busy%0d", i), busy_o, 1);
         checkOutput($sformatf("clr_wv%0d", i), ram_wr_valid_o, 1);
         checkOutput($sformatf("clr_wa%0d", i), ram_wr_addr_o, i);
         checkOutput($sformatf("clr_wd%0d", i), ram_wr_data_o, 0);
         checkOutput($sformatf("clr_rdy%0d", i),
                     {wr0_ready_o, wr1_ready_o, rd0_ready_o, rd1_ready_o}, 0);
         idle();
         tick();
      end
`endif
      idle();
      checkOutput("run_busy", busy_o, 0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
      reset_ni = 1'b0;
      idle();
      tick();
      tick();

      // Reset state
      checkOutput("rst_rv0", rd0_rvalid_o, 0);
      checkOutput("rst_rv1", rd1_rvalid_o, 0);
      checkOutput("rst_rd0", rd0_data_o, 0);
      checkOutput("rst_rd1", rd1_data_o, 0);
      checkOutput("rst_wv", ram_wr_valid_o, 0);
`ifdef RAM_1R1W_ARB_CLEAR_EN
      checkOutput("rst_busy", busy_o, 1);
`else
      checkOutput("rst_busy", busy_o, 0);
`endif

      releaseAndClear();

      // Both writers valid for 4 cycles from pointer 0: grants 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 4, 8'h40, 1, 5, 8'h50, 0, 0, 0, 0);
         checkOutput($sformatf("rr_w0rdy%0d", i), wr0_ready_o, (i % 2) == 0);
         checkOutput($sformatf("rr_w1rdy%0d", i), wr1_ready_o, (i % 2) == 1);
         checkOutput($sformatf("rr_wv%0d", i), ram_wr_valid_o, 1);
         checkOutput($sformatf("rr_wa%0d", i), ram_wr_addr_o, ((i % 2) == 0) ? 4 : 5);
         tick();
      end
      idle();
      checkOutput("idle_wv", ram_wr_valid_o, 0);

      // wr1 writes A5 to address 3, then rd0 reads it back
      applyStimulus(0, 0, 0, 1, 3, 8'hA5, 0, 0, 0, 0);
      checkOutput("a5_w1rdy", wr1_ready_o, 1);
      checkOutput("a5_wa", ram_wr_addr_o, 3);
      checkOutput("a5_wd", ram_wr_data_o, 8'hA5);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      checkOutput("a5_r0rdy", rd0_ready_o, 1);
      checkOutput("a5_ra", ram_rd_addr_o, 3);
      checkOutput("a5_rv_early", rd0_rvalid_o, 0);
      tick();
      idle();
      checkOutput("a5_rv", rd0_rvalid_o, 1);
      checkOutput("a5_rd", rd0_data_o, 8'hA5);
      checkOutput("a5_rv1", rd1_rvalid_o, 0);
      tick();
      checkOutput("a5_rv_drop", rd0_rvalid_o, 0);
      checkOutput("a5_hold", rd0_data_o, 8'hA5);

      // Same-cycle write and read of address 2 returns the old value
      applyStimulus(1, 2, 8'h11, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("old_w0rdy", wr0_ready_o, 1);
      tick();
      applyStimulus(1, 2, 8'h5A, 0, 0, 0, 0, 0, 1, 2);
      checkOutput("raw_w0rdy", wr0_ready_o, 1);
      checkOutput("raw_r1rdy", rd1_ready_o, 1);
      tick();
      idle();
      checkOutput("raw_rv", rd1_rvalid_o, 1);
      checkOutput("raw_old", rd1_data_o, 8'h11);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      tick();
      idle();
      checkOutput("raw_new", rd1_data_o, 8'h5A);

      // Both readers valid: pointer is 0 after the rd1 grant, so rd0 then rd1
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1, 2);
      checkOutput("rrr_r0rdy", rd0_ready_o, 1);
      checkOutput("rrr_r1rdy", rd1_ready_o, 0);
      tick();
      checkOutput("rrr_rv0a", rd0_rvalid_o, 1);
      checkOutput("rrr_rd0", rd0_data_o, 8'hA5);
      checkOutput("rrr_rv1a", rd1_rvalid_o, 0);
      checkOutput("rrr_r1rdy2", rd1_ready_o, 1);
      tick();
      idle();
      checkOutput("rrr_rv0b", rd0_rvalid_o, 0);
      checkOutput("rrr_rv1b", rd1_rvalid_o, 1);
      checkOutput("rrr_rd1", rd1_data_o, 8'h5A);
      tick();

      // Read granted, then reset before the response edge
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      checkOutput("rst_r0rdy", rd0_ready_o, 1);
      reset_ni = 1'b0;
      #1;
      idle();
      tick();
      checkOutput("midrst_rv0", rd0_rvalid_o, 0);
      checkOutput("midrst_rd0", rd0_data_o, 0);
      reset_ni = 1'b1;
      #1;
      checkOutput("post_rv0a", rd0_rvalid_o, 0);
      tick();
      checkOutput("post_rv0b", rd0_rvalid_o, 0);
      checkOutput("post_rv1b", rd1_rvalid_o, 0);

`ifdef RAM_1R1W_ARB_CLEAR_EN
      // Reset during CLEAR at counter 5 restarts the sweep from address 0
      reset_ni = 1'b0;
      tick();
      reset_ni = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("clr5_wa", ram_wr_addr_o, 5);
      checkOutput("clr5_busy", busy_o, 1);
      reset_ni = 1'b0;
      tick();
      releaseAndClear();
`else
      tick();
`endif

      // Write pointer is back at 0 after reset: wr0 wins a tie
      applyStimulus(1, 6, 8'h06, 1, 7, 8'h07, 0, 0, 0, 0);
      checkOutput("ptr_w0rdy", wr0_ready_o, 1);
      checkOutput("ptr_w1rdy", wr1_ready_o, 0);
      checkOutput("ptr_wa", ram_wr_addr_o, 6);
      tick();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
